// File: rtl/fast_square_tx.sv
// fast_square_tx
//   Multi-tone square-wave transmitter. Synthesises NUM_SUBCARRIERS complex
//   square-wave tones at carrier + {-3S,-S,+S,+3S} and sums them into one
//   16-bit I/Q stream. All tone frequencies are stepped together on
//   freq_step using the same small/large step schedule as the receiver.
//
//   Optional feature macro: FAST_SQUARE_TX_RAMP_EN
//     defined   -> RAMP_UP/RAMP_DOWN states with a 2^RAMP_LOG2-strobe
//                  amplitude ramp on burst start/stop
//     undefined -> direct IDLE<->ACTIVE, full amplitude from first strobe
//
// Ports
//   clock, reset         system clock, asynchronous active-high reset
//   transmit             level: high = generate tones, low = go idle
//   freq_step            pulse: advance all tone frequencies one step
//   sample_strobe        pulse: advance phases, register next I/Q sample
//   serial_addr/data/strobe  setting-bus write port
//   i_out, q_out         registered signed I/Q samples
//   active               high while not IDLE
//   step_count           freq_step pulses accepted in the current burst
module fast_square_tx #(
  parameter int unsigned CARRIERFREQADDR    = 4,
  parameter int unsigned SUBCARRIERFREQADDR = 5,
  parameter int unsigned AMPLADDR           = 6,
  parameter int unsigned NUM_SUBCARRIERS    = 4,
  parameter int unsigned RAMP_LOG2          = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        transmit,
  input  logic        freq_step,
  input  logic        sample_strobe,
  input  logic [6:0]  serial_addr,
  input  logic [31:0] serial_data,
  input  logic        serial_strobe,
  output logic [15:0] i_out,
  output logic [15:0] q_out,
  output logic        active,
  output logic [15:0] step_count
);

  localparam logic [31:0] STEP_BASE = 32'd1789569706;
  localparam logic [12:0] AMP_MAX   = 13'd8191;
  localparam int unsigned GAIN_W    = RAMP_LOG2 + 1;
  localparam logic [GAIN_W-1:0] GAIN_FULL = {1'b1, {RAMP_LOG2{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACTIVE,
    S_RAMP_UP,
    S_RAMP_DOWN
  } state_t;

  state_t      r_state;

  // setting-bus registers (writable at any time)
  logic [31:0] r_carrier_set;
  logic [31:0] r_sub_set;
  logic [15:0] r_ampl_set;

  // working registers, latched on burst start
  logic [31:0] r_fc;
  logic [31:0] r_f [NUM_SUBCARRIERS];
  logic [31:0] r_step_small;
  logic [31:0] r_step_large;
  logic [12:0] r_amp;

  // phase accumulators and outputs
  logic [31:0] r_pc;
  logic [31:0] r_p [NUM_SUBCARRIERS];
  logic [15:0] r_i_out;
  logic [15:0] r_q_out;
  logic [15:0] r_step_count;

  logic [31:0] w_sub3;
  logic [31:0] w_f_init [NUM_SUBCARRIERS];
  logic [31:0] w_step_small_init;
  logic [31:0] w_step_large_init;
  logic [12:0] w_amp_init;
  logic        w_use_large;
  logic [31:0] w_step;
  logic [GAIN_W-1:0]    w_gain_sel;
  logic [13+GAIN_W-1:0] w_prod;
  logic [15:0] w_tone_amp;
  logic [15:0] w_tone_neg;
  logic [15:0] w_tphase [NUM_SUBCARRIERS];
  logic [15:0] w_i_sum;
  logic [15:0] w_q_sum;
  logic        w_exit;

  // ---------------- setting bus ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_carrier_set <= '0;
      r_sub_set     <= '0;
      r_ampl_set    <= '0;
    end else if (serial_strobe) begin
      if (serial_addr == 7'(CARRIERFREQADDR))    r_carrier_set <= serial_data;
      if (serial_addr == 7'(SUBCARRIERFREQADDR)) r_sub_set     <= serial_data;
      if (serial_addr == 7'(AMPLADDR))           r_ampl_set    <= serial_data[15:0];
    end
  end

  // ---------------- burst-start values ----------------
  assign w_sub3            = r_sub_set + (r_sub_set << 1);
  assign w_step_small_init = STEP_BASE - (w_sub3 << 1);
  assign w_step_large_init = STEP_BASE - (r_sub_set << 3);
  assign w_amp_init        = (r_ampl_set > 16'd8191) ? AMP_MAX : r_ampl_set[12:0];

  always_comb begin
    w_f_init[0] = '0 - w_sub3;
    w_f_init[1] = '0 - r_sub_set;
    w_f_init[2] = r_sub_set;
    w_f_init[3] = w_sub3;
  end

  // ---------------- frequency step selection ----------------
  assign w_use_large = $signed(r_f[1]) > -$signed(r_step_small);
  assign w_step      = w_use_large ? r_step_large : r_step_small;

  // ---------------- amplitude (optionally ramped) ----------------
`ifdef FAST_SQUARE_TX_RAMP_EN
  logic [GAIN_W-1:0] r_gain;
  // the down-ramp sample uses the gain it is about to decrement to
  assign w_gain_sel = (r_state == S_RAMP_DOWN) ? r_gain - GAIN_W'(1) : r_gain;
  assign w_exit     = (r_state == S_RAMP_DOWN) && (r_gain == '0);
`else
  assign w_gain_sel = GAIN_FULL;
  assign w_exit     = !transmit;
`endif

  assign w_prod     = {{GAIN_W{1'b0}}, r_amp} * {{13{1'b0}}, w_gain_sel};
  assign w_tone_amp = 16'(w_prod >> RAMP_LOG2);
  assign w_tone_neg = '0 - w_tone_amp;

  // ---------------- tone synthesis ----------------
  // t[15]==t[14] is the same as t in the first or last quarter turn;
  // t[15]==0 is the same as t in the first half turn.
  always_comb begin
    w_i_sum = '0;
    w_q_sum = '0;
    for (int unsigned k = 0; k < NUM_SUBCARRIERS; k++) begin
      w_tphase[k] = r_pc[31:16] + r_p[k][31:16];
      w_i_sum = w_i_sum + (((w_tphase[k] < 16'h4000) || (w_tphase[k] >= 16'hC000))
                           ? w_tone_amp : w_tone_neg);
      w_q_sum = w_q_sum + ((w_tphase[k] < 16'h8000) ? w_tone_amp : w_tone_neg);
    end
  end

  // ---------------- control FSM ----------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state      <= S_IDLE;
      r_fc         <= '0;
      r_step_small <= '0;
      r_step_large <= '0;
      r_amp        <= '0;
      r_pc         <= '0;
      r_i_out      <= '0;
      r_q_out      <= '0;
      r_step_count <= '0;
      for (int unsigned k = 0; k < NUM_SUBCARRIERS; k++) begin
        r_f[k] <= '0;
        r_p[k] <= '0;
      end
`ifdef FAST_SQUARE_TX_RAMP_EN
      r_gain <= '0;
`endif
    end else begin
      case (r_state)
        S_IDLE: begin
          r_i_out <= '0;
          r_q_out <= '0;
          r_pc    <= '0;
          for (int unsigned k = 0; k < NUM_SUBCARRIERS; k++) r_p[k] <= '0;
          if (transmit) begin
            r_fc         <= r_carrier_set;
            r_step_small <= w_step_small_init;
            r_step_large <= w_step_large_init;
            r_amp        <= w_amp_init;
            r_step_count <= '0;
            for (int unsigned k = 0; k < NUM_SUBCARRIERS; k++) r_f[k] <= w_f_init[k];
`ifdef FAST_SQUARE_TX_RAMP_EN
            r_gain  <= '0;
            r_state <= S_RAMP_UP;
`else
            r_state <= S_ACTIVE;
`endif
          end
        end
        default: begin
          if (w_exit) begin
            r_state <= S_IDLE;
            r_i_out <= '0;
            r_q_out <= '0;
            r_pc    <= '0;
            for (int unsigned k = 0; k < NUM_SUBCARRIERS; k++) r_p[k] <= '0;
          end else begin
            // phases use the pre-step frequencies when both pulses coincide
            if (sample_strobe) begin
              r_i_out <= w_i_sum;
              r_q_out <= w_q_sum;
              r_pc    <= r_pc + r_fc;
              for (int unsigned k = 0; k < NUM_SUBCARRIERS; k++) r_p[k] <= r_p[k] + r_f[k];
            end
            if (freq_step) begin
              for (int unsigned k = 0; k < NUM_SUBCARRIERS; k++) r_f[k] <= r_f[k] + w_step;
              r_step_count <= r_step_count + 16'd1;
            end
`ifdef FAST_SQUARE_TX_RAMP_EN
            case (r_state)
              S_RAMP_UP: begin
                if (!transmit) begin
                  r_state <= S_RAMP_DOWN;
                end else if (sample_strobe) begin
                  r_gain <= r_gain + GAIN_W'(1);
                  if (r_gain == GAIN_FULL - GAIN_W'(1)) r_state <= S_ACTIVE;
                end
              end
              S_ACTIVE: begin
                if (!transmit) r_state <= S_RAMP_DOWN;
              end
              S_RAMP_DOWN: begin
                if (sample_strobe) r_gain <= r_gain - GAIN_W'(1);
              end
              default: ;
            endcase
`endif
          end
        end
      endcase
    end
  end

  assign i_out      = r_i_out;
  assign q_out      = r_q_out;
  assign active     = (r_state != S_IDLE);
  assign step_count = r_step_count;

endmodule
